point_label_compactor: RTL and testbench
========================================

# point_label_compactor

Downstream stage of the distance filter. Consumes the labelled point stream the filter writes back (point ID, custom-field label, coordinates), keeps only points whose label matches a configured value, buffers them in an internal FIFO, and re-emits them as a dense ready/valid stream terminated by a per-frame trailer beat carrying the kept-point count. It feeds clustering/readout logic that needs contiguous inside-range points, not the full sparse cloud.

## Interface
- DEPTH, 16, FIFO entries; power of two, 4..256
- KEEP_LABEL, 16'd2, label value that is kept (filter "inside" code)
- i_SYSTEM_clk  in  1  system clock, all logic on rising edge
- i_SYSTEM_rst  in  1  reset; synchronous, active-high
- in_valid  in  1  labelled point present
- in_ready  out  1  block accepts point this cycle
- in_id  in  19  point ID
- in_label  in  16  custom-field label
- in_x, in_y, in_z  in  16 each  signed coordinates
- in_frame_done  in  1  frame complete request (level, held until acked)
- in_frame_ack  out  1  one-cycle pulse: frame closed, trailer sent
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_last  out  1  beat is frame trailer
- out_id  out  19  point ID, or kept count on trailer
- out_x, out_y, out_z  out  16 each  coordinates; 0 on trailer
- o_kept_count  out  19  kept points of last closed frame
- o_status  out  32  [1:0] state, [10:2] FIFO occupancy, rest 0

## Operation
- States: COLLECT, DRAIN, TRAILER, ACK. Reset enters COLLECT.
- COLLECT: in_ready = (occupancy < DEPTH). Beat accepted when in_valid && in_ready. If in_label == KEEP_LABEL: push {id,x,y,z}, kept counter +1; otherwise discard (still accepted).
- COLLECT -> DRAIN when in_frame_done = 1. in_ready = 0 from that cycle on, until back in COLLECT. A beat presented in the same cycle as in_frame_done is not accepted.
- DRAIN: FIFO pops on out_valid && out_ready; -> TRAILER when occupancy = 0 and no pop pending.
- TRAILER: out_valid = 1, out_last = 1, out_id = kept counter, coords 0; held until out_ready. On handshake: o_kept_count <= kept counter, kept counter <= 0, -> ACK.
- ACK: in_frame_ack = 1 for one cycle, -> COLLECT. Upstream drops in_frame_done on ack.
- Output during COLLECT/DRAIN: FIFO head; out_valid = FIFO not empty; out_last = 0.
- Kept counter 19 bits; saturates at 2^19-1, never wraps.
- Empty frame (no kept points): trailer with out_id = 0 issued directly after DRAIN.
- Reset mid-frame: FIFO flushed, counters 0, partially collected frame lost, no trailer.

## Timing
- Reset values: in_ready 0 during reset cycle, 1 first cycle after; out_valid 0; out_last 0; out_id/out_x/out_y/out_z 0; in_frame_ack 0; o_kept_count 0; o_status 0 with state COLLECT.
- Kept point accepted in cycle N: on out_valid earliest cycle N+1.
- Full FIFO: in_ready low; simultaneous pop does not raise in_ready in same cycle (raised next cycle).
- out_* stable while out_valid && !out_ready.
- Trailer earliest one cycle after last FIFO pop; ack one cycle after trailer handshake.

## Configuration
- COMPACTOR_STATS_EN defined: adds o_dropped_count (out, 19) and o_stall_cycles (out, 32); dropped = labels != KEEP_LABEL in last closed frame (saturating, latched at trailer handshake like o_kept_count); stall = cycles with in_valid && !in_ready since reset (saturating). o_status[31:16] = low 16 bits of live dropped counter.
- Undefined: ports absent, counters not built, o_status[31:16] = 0.

## Structure
- Package compactor_pkg: ID_W = 19, COORD_W = 16, LABEL_W = 16, LABEL_INSIDE = 2, LABEL_OUTSIDE = 1, state enum codes (COLLECT 0, DRAIN 1, TRAILER 2, ACK 3).
- One sub-module: compactor_fifo, synchronous FIFO, width 67 (ID + 3 coords), depth DEPTH, push/pop/full/empty/occupancy, show-ahead head.
- FSM, counters and output mux in top.

## Test plan
- Labels 2,1,2,2,1 with IDs 0..4, out_ready = 1, then frame_done -> out IDs 0,2,3 then trailer out_id = 3, out_last = 1; o_kept_count = 3; one ack pulse.
- Empty frame: frame_done with no input -> single trailer out_id = 0, ack, back to COLLECT, in_ready = 1.
- DEPTH = 4, 6 label-2 points, out_ready = 0 -> in_ready low after 4th accept; raise out_ready -> IDs 0..5 in order, none lost or duplicated.
- out_ready toggling every cycle during DRAIN -> data stable while stalled; trailer only after last point.
- Reset asserted with 3 entries buffered -> out_valid 0, o_status occupancy 0, next frame trailer counts only new points.
- COMPACTOR_STATS_EN: 5 points, 2 kept -> o_dropped_count = 3 after trailer; 4 stall cycles forced -> o_stall_cycles = 4.

Source files
------------

// File: rtl/compactor_pkg.sv
// compactor_pkg: shared widths, label codes, FSM state codes and FIFO entry layout for point_label_compactor
package compactor_pkg;
  localparam int ID_W = 19;
  localparam int COORD_W = 16;
  localparam int LABEL_W = 16;
  localparam logic [LABEL_W-1:0] LABEL_INSIDE = 16'd2;
  localparam logic [LABEL_W-1:0] LABEL_OUTSIDE = 16'd1;
  localparam int ENTRY_W = ID_W + 3 * COORD_W;
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    TRAILER = 2'd2,
    ACK     = 2'd3
  } state_t;
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } entry_t;
  function automatic logic [ID_W-1:0] sat_inc(input logic [ID_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/compactor_fifo.sv
// compactor_fifo: synchronous show-ahead FIFO, power-of-two depth, pointer-only flush on reset
module compactor_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 67
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q, count_d;
  logic wr, rd;
  assign wr = push_i && !full_o;
  assign rd = pop_i && !empty_o;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign head_o = mem_q[rptr_q];
  // occupancy after this cycle's push/pop
  always_comb count_d = count_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
  // pointers and occupancy; storage is not reset, pointers alone define contents
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      if (wr) mem_q[wptr_q] <= din_i;
      wptr_q <= wptr_q + AW'(wr);
      rptr_q <= rptr_q + AW'(rd);
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/point_label_compactor.sv
// point_label_compactor: keeps label-matching points, re-emits them densely with a per-frame count trailer (option COMPACTOR_STATS_EN adds drop/stall stats)
module point_label_compactor
  import compactor_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter logic [LABEL_W-1:0] KEEP_LABEL = LABEL_INSIDE
) (
  input  logic                 i_SYSTEM_clk,
  input  logic                 i_SYSTEM_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ID_W-1:0]      in_id,
  input  logic [LABEL_W-1:0]   in_label,
  input  logic [COORD_W-1:0]   in_x,
  input  logic [COORD_W-1:0]   in_y,
  input  logic [COORD_W-1:0]   in_z,
  input  logic                 in_frame_done,
  output logic                 in_frame_ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [ID_W-1:0]      out_id,
  output logic [COORD_W-1:0]   out_x,
  output logic [COORD_W-1:0]   out_y,
  output logic [COORD_W-1:0]   out_z,
  output logic [ID_W-1:0]      o_kept_count,
  output logic [31:0]          o_status
`ifdef COMPACTOR_STATS_EN
  ,
  output logic [ID_W-1:0]      o_dropped_count,
  output logic [31:0]          o_stall_cycles
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state_q, state_d;
  logic [ID_W-1:0] kept_q, kept_d, kept_count_q;
  logic [CW-1:0] occ;
  logic full, empty, accept, keep, trl, trl_hs, fifo_pop;
  entry_t head, din;
  logic [15:0] stat_hi;
  assign trl = state_q == TRAILER;
  assign trl_hs = trl && out_ready;
  assign in_ready = !i_SYSTEM_rst && state_q == COLLECT && !in_frame_done && !full;
  assign accept = in_valid && in_ready;
  assign keep = accept && in_label == KEEP_LABEL;
  assign fifo_pop = out_ready && !empty;
  assign din = '{id: in_id, x: in_x, y: in_y, z: in_z};
  compactor_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk_i(i_SYSTEM_clk),
    .rst_i(i_SYSTEM_rst),
    .push_i(keep),
    .pop_i(fifo_pop),
    .din_i(din),
    .head_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(occ)
  );
  assign out_valid = trl || !empty;
  assign out_last = trl;
  assign out_id = trl ? kept_q : (empty ? '0 : head.id);
  assign out_x = empty ? '0 : head.x;
  assign out_y = empty ? '0 : head.y;
  assign out_z = empty ? '0 : head.z;
  assign in_frame_ack = state_q == ACK;
  assign o_kept_count = kept_count_q;
  assign o_status = {stat_hi, 5'd0, 9'(occ), state_q};
  // frame sequencing; DRAIN leaves as soon as the final pop is under way
  always_comb
    state_d = (state_q == COLLECT && in_frame_done) ? DRAIN :
              (state_q == DRAIN && (empty || (occ == CW'(1) && fifo_pop))) ? TRAILER :
              (state_q == TRAILER && out_ready) ? ACK :
              (state_q == ACK) ? COLLECT : state_q;
  // kept counter clears once the trailer has carried it out
  always_comb kept_d = trl_hs ? '0 : keep ? sat_inc(kept_q) : kept_q;
  // state, live kept counter and last-frame kept count
  always_ff @(posedge i_SYSTEM_clk) begin
    if (i_SYSTEM_rst) begin
      state_q <= COLLECT;
      kept_q <= '0;
      kept_count_q <= '0;
    end else begin
      state_q <= state_d;
      kept_q <= kept_d;
      if (trl_hs) kept_count_q <= kept_q;
    end
  end
`ifdef COMPACTOR_STATS_EN
  logic [ID_W-1:0] drop_q, drop_count_q;
  logic [31:0] stall_q;
  assign o_dropped_count = drop_count_q;
  assign o_stall_cycles = stall_q;
  assign stat_hi = drop_q[15:0];
  // discarded-label and input-stall statistics, both saturating
  always_ff @(posedge i_SYSTEM_clk) begin
    if (i_SYSTEM_rst) begin
      drop_q <= '0;
      drop_count_q <= '0;
      stall_q <= '0;
    end else begin
      drop_q <= trl_hs ? '0 : (accept && in_label != KEEP_LABEL) ? sat_inc(drop_q) : drop_q;
      if (trl_hs) drop_count_q <= drop_q;
      if (in_valid && !in_ready && !(&stall_q)) stall_q <= stall_q + 32'd1;
    end
  end
`else
  assign stat_hi = '0;
`endif
endmodule

// File: tb/tb_point_label_compactor.sv
// tb_point_label_compactor: directed self-checking bench for point_label_compactor (DEPTH 4; stats checks under COMPACTOR_STATS_EN)
module tb_point_label_compactor;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic        last;
    logic [18:0] id;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } beat_t;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_frame_done = 0, in_frame_ack;
  logic [18:0] in_id = 0;
  logic [15:0] in_label = 0, in_x = 0, in_y = 0, in_z = 0;
  logic out_valid, out_ready = 0, out_last;
  logic [18:0] out_id, o_kept_count;
  logic [15:0] out_x, out_y, out_z;
  logic [31:0] o_status;
`ifdef COMPACTOR_STATS_EN
  logic [18:0] o_dropped_count;
  logic [31:0] o_stall_cycles;
`endif
  beat_t q[$];
  int errors = 0, checks = 0, acks = 0;
  point_label_compactor #(.DEPTH(DEPTH), .KEEP_LABEL(16'd2)) dut (
    .i_SYSTEM_clk(clk),
    .i_SYSTEM_rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_id(in_id),
    .in_label(in_label),
    .in_x(in_x),
    .in_y(in_y),
    .in_z(in_z),
    .in_frame_done(in_frame_done),
    .in_frame_ack(in_frame_ack),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .out_id(out_id),
    .out_x(out_x),
    .out_y(out_y),
    .out_z(out_z),
    .o_kept_count(o_kept_count),
    .o_status(o_status)
`ifdef COMPACTOR_STATS_EN
    ,
    .o_dropped_count(o_dropped_count),
    .o_stall_cycles(o_stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) q.push_back({out_last, out_id, out_x, out_y, out_z});
      if (in_frame_ack) acks++;
    end
  end
  function automatic logic [15:0] xv(int id); return 16'(id + 'h100); endfunction
  function automatic logic [15:0] yv(int id); return 16'(id * 2); endfunction
  function automatic logic [15:0] zv(int id); return 16'('hF000 + id); endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(int id, int lab);
    int n = 0;
    in_valid = 1;
    in_id = 19'(id);
    in_label = 16'(lab);
    in_x = xv(id);
    in_y = yv(id);
    in_z = zv(id);
    #1;
    while (!in_ready && n < 50) begin
      step();
      #1;
      n++;
    end
    check("send_wait", 32'(n < 50), 1);
    step();
    in_valid = 0;
  endtask
  task automatic frame();
    int n = 0;
    int a0 = acks;
    in_frame_done = 1;
    #1;
    while (!in_frame_ack && n < 100) begin
      step();
      #1;
      n++;
    end
    check("ack_wait", 32'(n < 100), 1);
    in_frame_done = 0;
    step();
    check("ack_pulse_low", in_frame_ack, 0);
    check("ack_count", acks - a0, 1);
  endtask
  task automatic chk_beat(string tag, int i, logic last, int id);
    check({tag, "_last"}, q[i].last, last);
    check({tag, "_id"}, q[i].id, 32'(id));
    check({tag, "_x"}, q[i].x, last ? 0 : xv(id));
    check({tag, "_y"}, q[i].y, last ? 0 : yv(id));
    check({tag, "_z"}, q[i].z, last ? 0 : zv(id));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
  initial begin
    int n;
    logic stalled, plast;
    logic [18:0] pid;
    logic [15:0] px;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_x", out_x, 0);
    check("rst_ack", in_frame_ack, 0);
    check("rst_kept", o_kept_count, 0);
    check("rst_status", o_status, 0);
    rst = 0;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    out_ready = 1;
    q.delete();
    send(0, 2);
    check("t1_latency_valid", out_valid, 1);
    check("t1_latency_id", out_id, 0);
    send(1, 1);
    send(2, 2);
    send(3, 2);
    send(4, 1);
    frame();
    check("t1_qsize", q.size(), 4);
    chk_beat("t1_b0", 0, 0, 0);
    chk_beat("t1_b1", 1, 0, 2);
    chk_beat("t1_b2", 2, 0, 3);
    chk_beat("t1_trl", 3, 1, 3);
    check("t1_kept", o_kept_count, 3);
    q.delete();
    frame();
    check("t2_qsize", q.size(), 1);
    chk_beat("t2_trl", 0, 1, 0);
    check("t2_kept", o_kept_count, 0);
    #1;
    check("t2_in_ready", in_ready, 1);
    check("t2_state", o_status[1:0], 0);
    out_ready = 0;
    q.delete();
    for (int i = 0; i < 4; i++) send(100 + i, 2);
    in_valid = 1;
    #1;
    check("t3_full_in_ready", in_ready, 0);
    check("t3_full_occ", o_status[10:2], 4);
    check("t3_head_id", out_id, 100);
    out_ready = 1;
    #1;
    check("t3_pop_same_cycle", in_ready, 0);
    step();
    in_valid = 0;
    #1;
    check("t3_ready_after_pop", in_ready, 1);
    send(104, 2);
    send(105, 2);
    frame();
    check("t3_qsize", q.size(), 7);
    for (int i = 0; i < 6; i++) chk_beat("t3_b", i, 0, 100 + i);
    chk_beat("t3_trl", 6, 1, 6);
    out_ready = 0;
    q.delete();
    send(200, 2);
    send(201, 2);
    send(202, 2);
    in_frame_done = 1;
    #1;
    stalled = 0;
    pid = 0;
    px = 0;
    plast = 0;
    n = 0;
    while (!in_frame_ack && n < 80) begin
      if (stalled) begin
        check("t4_hold_valid", out_valid, 1);
        check("t4_hold_id", out_id, pid);
        check("t4_hold_x", out_x, px);
        check("t4_hold_last", out_last, plast);
      end
      out_ready = ~out_ready;
      #1;
      stalled = out_valid && !out_ready;
      pid = out_id;
      px = out_x;
      plast = out_last;
      step();
      #1;
      n++;
    end
    check("t4_ack_seen", 32'(n < 80), 1);
    in_frame_done = 0;
    step();
    out_ready = 1;
    check("t4_qsize", q.size(), 4);
    chk_beat("t4_b0", 0, 0, 200);
    chk_beat("t4_b1", 1, 0, 201);
    chk_beat("t4_b2", 2, 0, 202);
    chk_beat("t4_trl", 3, 1, 3);
    out_ready = 0;
    q.delete();
    send(300, 2);
    send(301, 2);
    send(302, 2);
    check("t5_occ_before", o_status[10:2], 3);
    rst = 1;
    step();
    rst = 0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_status", o_status, 0);
    check("t5_kept", o_kept_count, 0);
    out_ready = 1;
    send(310, 2);
    send(311, 1);
    send(312, 2);
    frame();
    check("t5_qsize", q.size(), 3);
    chk_beat("t5_b0", 0, 0, 310);
    chk_beat("t5_b1", 1, 0, 312);
    chk_beat("t5_trl", 2, 1, 2);
`ifdef COMPACTOR_STATS_EN
    rst = 1;
    step();
    rst = 0;
    out_ready = 1;
    q.delete();
    send(400, 2);
    send(401, 1);
    send(402, 1);
    send(403, 2);
    send(404, 1);
    out_ready = 0;
    in_frame_done = 1;
    in_valid = 1;
    in_label = 16'd2;
    repeat (4) step();
    in_valid = 0;
    #1;
    check("t6_live_dropped", o_status[31:16], 3);
    check("t6_stall_live", o_stall_cycles, 4);
    out_ready = 1;
    frame();
    check("t6_dropped", o_dropped_count, 3);
    check("t6_kept", o_kept_count, 2);
    check("t6_stall", o_stall_cycles, 4);
    check("t6_live_cleared", o_status[31:16], 0);
    check("t6_qsize", q.size(), 3);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
